pe_operand_issue: RTL and testbench
===================================

Name: pe_operand_issue

Overview:
- Operand-collection and issue stage that sits directly upstream of the PE's combinational functional unit. It also registers the FU's result for the PE output.
- Buffers operand A and operand B arriving from the interconnect on valid/ready channels. Fires the FU when both operands and the output slot are available, then captures the result into an output register with valid/ready toward the downstream router.
- A small start/iteration FSM bounds how many firings one configuration performs.

Parameters:
DATA_W, 32, operand/result width (matches FU datapath)
OP_W, 4, FU opcode width
DEPTH, 2, entries per operand FIFO (power of 2, >=2)
ITER_W, 16, iteration counter width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cfg_start  in  1  one-cycle pulse: latch cfg_opcode/cfg_iter, begin run
cfg_opcode  in  OP_W  FU operation for this run
cfg_iter  in  ITER_W  firings to perform; 0 = unbounded
in_a_data  in  DATA_W  operand A payload
in_a_valid  in  1  operand A valid
in_a_ready  out  1  operand A FIFO not full
in_b_data  in  DATA_W  operand B payload
in_b_valid  in  1  operand B valid
in_b_ready  out  1  operand B FIFO not full
fu_a  out  DATA_W  to FU operand a (A FIFO head)
fu_b  out  DATA_W  to FU operand b (B FIFO head or constant)
fu_opcode  out  OP_W  to FU, latched opcode
fu_result  in  DATA_W  from FU, combinational result
out_data  out  DATA_W  registered result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
busy  out  1  state is RUN or DRAIN
done  out  1  state is DONE
fire_cnt  out  ITER_W  firings completed in current run

Behaviour:
- Reset, synchronous, any state including mid-run:
  - Both FIFOs flushed; state IDLE.
  - in_*_ready=1 (FIFOs empty).
  - out_valid=0, out_data=0, fu_opcode=0, fire_cnt=0, busy=0, done=0.
- Operand FIFOs:
  - Push on valid&&ready.
  - ready = !full; there is no pass-through when full, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are legal when not full; occupancy is unchanged.
  - Pushes are accepted in every state, so preloading in IDLE/DONE is allowed.
  - Pointers wrap modulo DEPTH.
- fu_a/fu_b always show the FIFO heads; the value is don't-care when empty.
- fire = (state==RUN) && A nonempty && B nonempty && (!out_valid || out_ready).
- On fire:
  - Pop one entry from A and one from B.
  - out_data <= fu_result, out_valid <= 1.
  - fire_cnt <= fire_cnt+1, wrapping at 2^ITER_W.
  - Result latency: operands at head in cycle N, out_valid high in cycle N+1.
  - Back-to-back fires are allowed every cycle while out_ready=1.
- out_valid && out_ready && !fire -> out_valid <= 0.
- out_data is held stable while out_valid && !out_ready.
- FSM:
  - IDLE: cfg_start -> RUN; latch fu_opcode <= cfg_opcode and iter_lim <= cfg_iter; fire_cnt <= 0.
  - RUN, iter_lim!=0: a fire with fire_cnt==iter_lim-1 -> DRAIN. No further fires after that.
  - RUN, iter_lim==0: stays in RUN indefinitely; only rst exits.
  - DRAIN: the output register empties (out_valid==0, or out_valid&&out_ready this cycle) -> DONE.
  - DONE: done=1 held. cfg_start -> RUN with new config, same latching as IDLE.
- cfg_start in RUN or DRAIN is ignored.
- Operands left in the FIFOs at DONE are retained for the next run.

Optional Feature:
PE_CONST_OPERAND_EN
- Defined:
  - Adds input cfg_const[DATA_W] and input cfg_use_const[1], both latched on cfg_start.
  - When the latched use_const=1: fu_b = latched constant and the fire condition ignores B FIFO occupancy. B is not popped; in_b_ready still reflects the B FIFO.
- Undefined: the ports are absent and operand B always comes from the FIFO.

Test Plan:
1. Reset, cfg_start opcode=0 (ADD) iter=3; push A={1,2,3}, B={10,20,30}, out_ready=1 -> out_data 11,22,33 on consecutive cycles, fire_cnt=3, done=1 one cycle after the last out_valid handshake.
2. Push 3 entries to A with DEPTH=2 and no run active -> third push stalls: in_a_ready=0 after 2 pushes, FIFO contents preserved and consumed in order once RUN starts.
3. opcode=1 (SUB), iter=2, A={5,7}, B={2,1}, out_ready=0 for 4 cycles -> out_data=3 held stable, second fire blocked; release -> 3 then 6, then DONE.
4. iter=0, stream 20 pairs with out_ready=1 -> 20 results, never DONE, busy=1; cfg_start mid-run ignored (opcode unchanged).
5. rst asserted in RUN with 1 entry in each FIFO and out_valid=1 -> next cycle out_valid=0, both readys=1, state IDLE, fire_cnt=0.
6. PE_CONST_OPERAND_EN defined, cfg_const=4, use_const=1, opcode=2 (MULT), iter=2, A={3,5}, no B pushes -> out_data 12,20, then DONE.

Source files
------------

// File: rtl/pe_operand_issue.sv
// pe_operand_issue: operand collection and issue stage in front of the PE
// functional unit (FU). Operands A and B are buffered in small FIFOs. The FU
// fires when both heads are present and the result register can take a new
// value. The FU result is then registered toward the downstream router.
// A start/iteration FSM bounds how many firings one configuration performs.
//
// Optional feature macro: PE_CONST_OPERAND_EN. When it is defined, operand B
// can instead come from a constant that is latched at cfg_start.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   cfg_start/opcode/iter       start pulse and run configuration (iter 0 = unbounded)
//   cfg_const/cfg_use_const     constant operand B (PE_CONST_OPERAND_EN only)
//   in_a_*, in_b_*              operand valid/ready channels
//   fu_a, fu_b, fu_opcode       operands and opcode sent to the combinational FU
//   fu_result                   combinational FU result
//   out_data/valid/ready        registered result channel
//   busy, done, fire_cnt        run status
module pe_operand_issue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [OP_W-1:0]   cfg_opcode,
  input  logic [ITER_W-1:0] cfg_iter,
`ifdef PE_CONST_OPERAND_EN
  input  logic [DATA_W-1:0] cfg_const,
  input  logic              cfg_use_const,
`endif
  input  logic [DATA_W-1:0] in_a_data,
  input  logic              in_a_valid,
  output logic              in_a_ready,
  input  logic [DATA_W-1:0] in_b_data,
  input  logic              in_b_valid,
  output logic              in_b_ready,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  output logic [OP_W-1:0]   fu_opcode,
  input  logic [DATA_W-1:0] fu_result,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] fire_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state, state_nxt;
  logic              latch_cfg;
  logic [ITER_W-1:0] iter_lim;
  logic              fire, last_fire;
  logic              b_avail, pop_b;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0]  wr_a, rd_a, wr_b, rd_b;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic              push_a, push_b;

  // FIFO flags; ready depends only on fullness, with no pass-through
  assign in_a_ready = (cnt_a != CNT_W'(DEPTH));
  assign in_b_ready = (cnt_b != CNT_W'(DEPTH));
  assign push_a     = in_a_valid && in_a_ready;
  assign push_b     = in_b_valid && in_b_ready;
  assign fu_a       = mem_a[rd_a];

`ifdef PE_CONST_OPERAND_EN
  logic              use_const_q;
  logic [DATA_W-1:0] const_q;

  // Constant operand B, latched with the run configuration
  always_ff @(posedge clk) begin
    if (rst) begin
      use_const_q <= 1'b0;
      const_q     <= '0;
    end else if (latch_cfg) begin
      use_const_q <= cfg_use_const;
      const_q     <= cfg_const;
    end
  end

  assign fu_b    = use_const_q ? const_q : mem_b[rd_b];
  assign b_avail = use_const_q || (cnt_b != '0);
  assign pop_b   = fire && !use_const_q;
`else
  assign fu_b    = mem_b[rd_b];
  assign b_avail = (cnt_b != '0);
  assign pop_b   = fire;
`endif

  assign fire      = (state == S_RUN) && (cnt_a != '0) && b_avail &&
                     (!out_valid || out_ready);
  assign last_fire = (iter_lim != '0) && (fire_cnt == iter_lim - ITER_W'(1));

  // Operand A FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_a  <= '0;
      rd_a  <= '0;
      cnt_a <= '0;
    end else begin
      if (push_a) wr_a <= wr_a + PTR_W'(1);
      if (fire)   rd_a <= rd_a + PTR_W'(1);
      if (push_a && !fire)      cnt_a <= cnt_a + CNT_W'(1);
      else if (!push_a && fire) cnt_a <= cnt_a - CNT_W'(1);
    end
  end

  // Operand B FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_b  <= '0;
      rd_b  <= '0;
      cnt_b <= '0;
    end else begin
      if (push_b) wr_b <= wr_b + PTR_W'(1);
      if (pop_b)  rd_b <= rd_b + PTR_W'(1);
      if (push_b && !pop_b)      cnt_b <= cnt_b + CNT_W'(1);
      else if (!push_b && pop_b) cnt_b <= cnt_b - CNT_W'(1);
    end
  end

  // FIFO storage; contents beyond the pointers are don't-care
  always_ff @(posedge clk) begin
    if (push_a) mem_a[wr_a] <= in_a_data;
    if (push_b) mem_b[wr_b] <= in_b_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; cfg_start is honoured only in IDLE and DONE
  always_comb begin
    state_nxt = state;
    latch_cfg = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (cfg_start) begin
          state_nxt = S_RUN;
          latch_cfg = 1'b1;
        end
      end
      S_RUN:   if (fire && last_fire) state_nxt = S_DRAIN;
      S_DRAIN: if (!out_valid || out_ready) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status flags, registered from the next state so they track state exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done <= (state_nxt == S_DONE);
    end
  end

  // Configuration, firing counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      fu_opcode <= '0;
      iter_lim  <= '0;
      fire_cnt  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (latch_cfg) begin
        fu_opcode <= cfg_opcode;
        iter_lim  <= cfg_iter;
        fire_cnt  <= '0;
      end else if (fire) begin
        fire_cnt  <= fire_cnt + ITER_W'(1);
      end
      if (fire) begin
        out_data  <= fu_result;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_operand_issue.sv
// tb_pe_operand_issue: directed stimulus with a scoreboard queue. A negedge
// monitor pops the expected result on every out_valid/out_ready handshake.
module tb_pe_operand_issue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ITER_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [OP_W-1:0]   cfg_opcode;
  logic [ITER_W-1:0] cfg_iter;
  logic [DATA_W-1:0] cfg_const;
  logic              cfg_use_const;
  logic [DATA_W-1:0] in_a_data, in_b_data;
  logic              in_a_valid, in_b_valid, in_a_ready, in_b_ready;
  logic [DATA_W-1:0] fu_a, fu_b, fu_result, out_data;
  logic [OP_W-1:0]   fu_opcode;
  logic              out_valid, out_ready, busy, done;
  logic [ITER_W-1:0] fire_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_q [$];
  int          hs_cyc_q [$];

  pe_operand_issue #(.DATA_W(DATA_W), .OP_W(OP_W), .DEPTH(2), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_opcode(cfg_opcode), .cfg_iter(cfg_iter),
`ifdef PE_CONST_OPERAND_EN
    .cfg_const(cfg_const), .cfg_use_const(cfg_use_const),
`endif
    .in_a_data(in_a_data), .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
    .in_b_data(in_b_data), .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
    .fu_a(fu_a), .fu_b(fu_b), .fu_opcode(fu_opcode), .fu_result(fu_result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .fire_cnt(fire_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in FU: 0 ADD, 1 SUB, 2 MULT, otherwise XOR
  always_comb begin
    case (fu_opcode)
      4'd0:    fu_result = fu_a + fu_b;
      4'd1:    fu_result = fu_a - fu_b;
      4'd2:    fu_result = fu_a * fu_b;
      default: fu_result = fu_a ^ fu_b;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: a handshake visible at negedge completes at the next posedge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_unexpected: got %0d expected no output (cycle %0d)", out_data, cyc);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [OP_W-1:0] op, input logic [ITER_W-1:0] it);
    cfg_start  = 1'b1;
    cfg_opcode = op;
    cfg_iter   = it;
    tick();
    cfg_start  = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] d);
    bit ok = 1'b0;
    @(negedge clk);
    in_a_valid = 1'b1;
    in_a_data  = d;
    for (int k = 0; k < 200; k++) begin
      if (in_a_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tick();
    in_a_valid = 1'b0;
    check("push_a_accepted", 32'(ok), 32'd1);
  endtask

  task automatic push_b(input logic [31:0] d);
    bit ok = 1'b0;
    @(negedge clk);
    in_b_valid = 1'b1;
    in_b_data  = d;
    for (int k = 0; k < 200; k++) begin
      if (in_b_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tick();
    in_b_valid = 1'b0;
    check("push_b_accepted", 32'(ok), 32'd1);
  endtask

  // Pushes one A and one B in the same cycle, once both FIFOs have room
  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_a_ready && in_b_ready) begin ok = 1'b1; break; end
    end
    in_a_valid = 1'b1; in_a_data = a;
    in_b_valid = 1'b1; in_b_data = b;
    tick();
    in_a_valid = 1'b0;
    in_b_valid = 1'b0;
    if (!ok) check("push_pair_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(output int dc);
    bit ok = 1'b0;
    dc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; dc = cyc; break; end
    end
    check("done_reached", 32'(ok), 32'd1);
    tick();
  endtask

  task automatic wait_drained();
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
    check("scoreboard_drain", 32'(ok), 32'd1);
    tick();
  endtask

  initial begin
    int dc;
    int n;
    rst = 1'b1; cfg_start = 1'b0; cfg_opcode = '0; cfg_iter = '0;
    cfg_const = '0; cfg_use_const = 1'b0;
    in_a_data = '0; in_b_data = '0; in_a_valid = 1'b0; in_b_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_a_ready", 32'(in_a_ready), 1);
    check("rst_in_b_ready", 32'(in_b_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_fire_cnt", 32'(fire_cnt), 0);
    check("rst_fu_opcode", 32'(fu_opcode), 0);

    // 1: ADD, 3 firings on consecutive cycles, done one cycle after last handshake
    start_run(4'd0, 16'd3);
    check("t1_busy", 32'(busy), 1);
    exp_q.push_back(32'd11); exp_q.push_back(32'd22); exp_q.push_back(32'd33);
    push_pair(32'd1, 32'd10);
    push_pair(32'd2, 32'd20);
    push_pair(32'd3, 32'd30);
    wait_done(dc);
    n = hs_cyc_q.size();
    check("t1_handshakes", 32'(n), 3);
    if (n >= 3) begin
      check("t1_consec_1", 32'(hs_cyc_q[n-2] - hs_cyc_q[n-3]), 1);
      check("t1_consec_2", 32'(hs_cyc_q[n-1] - hs_cyc_q[n-2]), 1);
      check("t1_done_timing", 32'(dc - hs_cyc_q[n-1]), 1);
    end
    check("t1_fire_cnt", 32'(fire_cnt), 3);
    check("t1_done", 32'(done), 1);
    check("t1_busy_low", 32'(busy), 0);

    // 2: preload in DONE, third A push stalls until the run pops
    push_a(32'd4);
    push_a(32'd5);
    check("t2_a_full", 32'(in_a_ready), 0);
    tick(); tick();
    check("t2_a_still_full", 32'(in_a_ready), 0);
    check("t2_still_done", 32'(done), 1);
    push_b(32'd100);
    push_b(32'd200);
    check("t2_b_full", 32'(in_b_ready), 0);
    exp_q.push_back(32'd104); exp_q.push_back(32'd205); exp_q.push_back(32'd306);
    fork
      push_a(32'd6);
      begin
        start_run(4'd0, 16'd3);
        push_b(32'd300);
      end
    join
    wait_done(dc);
    check("t2_fire_cnt", 32'(fire_cnt), 3);

    // 3: SUB with backpressure, result held stable, second fire blocked
    out_ready = 1'b0;
    start_run(4'd1, 16'd2);
    exp_q.push_back(32'd3); exp_q.push_back(32'd6);
    push_pair(32'd5, 32'd2);
    push_pair(32'd7, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(out_valid), 1);
      check("t3_hold_data", out_data, 32'd3);
      check("t3_hold_fire_cnt", 32'(fire_cnt), 1);
    end
    tick();
    out_ready = 1'b1;
    wait_done(dc);
    check("t3_fire_cnt", 32'(fire_cnt), 2);
    check("t3_opcode", 32'(fu_opcode), 1);

    // 4: unbounded run, 20 pairs, cfg_start mid-run ignored
    start_run(4'd0, 16'd0);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(32'(i * 3 + 1) + 32'(i * 5));
      push_pair(32'(i * 3 + 1), 32'(i * 5));
      if (i == 10) start_run(4'd1, 16'd7);
    end
    wait_drained();
    tick();
    check("t4_fire_cnt", 32'(fire_cnt), 20);
    check("t4_busy", 32'(busy), 1);
    check("t4_not_done", 32'(done), 0);
    check("t4_opcode_kept", 32'(fu_opcode), 0);

    // 5: reset mid-run with a held result and one entry in each FIFO
    out_ready = 1'b0;
    push_pair(32'd1, 32'd2);
    push_pair(32'd3, 32'd4);
    check("t5_pre_valid", 32'(out_valid), 1);
    check("t5_pre_a_ready", 32'(in_a_ready), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_out_valid", 32'(out_valid), 0);
    check("t5_out_data", out_data, 0);
    check("t5_in_a_ready", 32'(in_a_ready), 1);
    check("t5_in_b_ready", 32'(in_b_ready), 1);
    check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(done), 0);
    check("t5_fire_cnt", 32'(fire_cnt), 0);
    check("t5_fu_opcode", 32'(fu_opcode), 0);
    out_ready = 1'b1;
    start_run(4'd0, 16'd1);
    exp_q.push_back(32'd17);
    push_pair(32'd8, 32'd9);
    wait_done(dc);
    check("t5_fire_cnt_after", 32'(fire_cnt), 1);

`ifdef PE_CONST_OPERAND_EN
    // 6: constant operand B, MULT, no B pushes
    cfg_const = 32'd4;
    cfg_use_const = 1'b1;
    start_run(4'd2, 16'd2);
    exp_q.push_back(32'd12); exp_q.push_back(32'd20);
    push_a(32'd3);
    push_a(32'd5);
    wait_done(dc);
    check("t6_fire_cnt", 32'(fire_cnt), 2);
    check("t6_in_b_ready", 32'(in_b_ready), 1);
    cfg_use_const = 1'b0;
`endif

    repeat (3) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
